// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and shift direction.
// The op code constants are the same values the ALU control decoder produces.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SRL) || (op == ALU_SLL);
    endfunction

    function automatic logic is_supported(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_XOR) || is_shift(op);
    endfunction

    // Single-cycle ops; anything unsupported yields zero.
    function automatic logic [31:0] alu_comb(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_XOR: r = a ^ b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU.
// The err signal exists only when ALU_ERR_EN is defined.
interface alu_seq_if;
    logic        start;
    logic [3:0]  aluCtrl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_ERR_EN
    logic        err;
`endif

    modport master (
        output start, aluCtrl, srcA, srcB,
        input  busy, done, result, zero
`ifdef ALU_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  start, aluCtrl, srcA, srcB,
        output busy, done, result, zero
`ifdef ALU_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter: holds operand, remaining count and direction.
// data_next is the operand shifted once more; last flags the final step.
module alu_shifter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  shift_dir_t  dir,
    input  logic [31:0] load_data,
    input  logic [4:0]  load_amt,
    output logic [31:0] data_next,
    output logic        last
);

    logic [31:0] data_reg;
    logic [4:0]  cnt_reg;
    shift_dir_t  dir_reg;
    logic [31:0] shl;
    logic [31:0] shr;

    // Zero fill enters at bit 0 for left shifts and at bit 31 for right shifts.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign shl[gi] = 1'b0;
            end else begin : g_shl
                assign shl[gi] = data_reg[gi-1];
            end
            if (gi == 31) begin : g_msb
                assign shr[gi] = 1'b0;
            end else begin : g_shr
                assign shr[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    assign data_next = (dir_reg == SHIFT_RIGHT) ? shr : shl;
    assign last      = (cnt_reg == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= 32'd0;
            cnt_reg  <= 5'd0;
            dir_reg  <= SHIFT_LEFT;
        end else if (load) begin
            data_reg <= load_data;
            cnt_reg  <= load_amt;
            dir_reg  <= dir;
        end else if (step && (cnt_reg != 5'd0)) begin
            data_reg <= data_next;
            cnt_reg  <= cnt_reg - 5'd1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: IDLE/SHIFT/DONE control, single-cycle add/sub/xor, output registers.
// Define ALU_ERR_EN to add the err flag for unsupported op codes.
module alu_seq
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    state_t      state_reg, state_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next;
    logic        err_reg, err_next;
    logic        update;
    logic        sh_load;
    logic        sh_last;
    logic [31:0] sh_data_next;
    shift_dir_t  sh_dir;

    assign sh_dir = (bus.aluCtrl == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;

    alu_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .step      (state_reg == SHIFT),
        .dir       (sh_dir),
        .load_data (bus.srcA),
        .load_amt  (bus.srcB[4:0]),
        .data_next (sh_data_next),
        .last      (sh_last)
    );

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        err_next    = err_reg;
        update      = 1'b0;
        sh_load     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    if (is_shift(bus.aluCtrl) && (bus.srcB[4:0] != 5'd0)) begin
                        sh_load    = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        // Zero-amount shifts pass srcA straight through.
                        state_next  = DONE;
                        update      = 1'b1;
                        result_next = is_shift(bus.aluCtrl) ? bus.srcA
                                    : alu_comb(bus.aluCtrl, bus.srcA, bus.srcB);
                        err_next    = !is_supported(bus.aluCtrl);
                    end
                end
            end
            SHIFT: begin
                if (sh_last) begin
                    state_next  = DONE;
                    update      = 1'b1;
                    result_next = sh_data_next;
                    err_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        zero_next = update ? (result_next == 32'd0) : zero_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            result_reg <= 32'd0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            err_reg    <= err_next;
        end
    end

    assign bus.busy   = (state_reg == SHIFT);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.zero   = zero_reg;
`ifdef ALU_ERR_EN
    assign bus.err    = err_reg;
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: start  input  1  request; accepted when busy=0.
REQ-004 SHALL have: aluCtrl  input  4  op code (0010 add, 0110 sub, 0011 xor, 0100 srl, 0101 sll).
REQ-005 SHALL have: srcA  input  32  first operand; srcB  input  32  second operand / shift amount in [4:0].
REQ-006 SHALL have: busy  output  1  high while a shift is iterating.
REQ-007 SHALL have: done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have: result  output  32  registered result; zero  output  1  registered (result==0).
REQ-009 SHALL have, only under ALU_ERR_EN: err  output  1  unsupported code flag, qualified by done.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE; busy = (state==SHIFT).
REQ-011 SHALL accept start in IDLE or DONE; start during SHIFT SHALL be ignored, not queued.
REQ-012 SHALL latch aluCtrl, srcA, srcB[4:0] on the accepting edge; later input changes SHALL not affect the op.
REQ-013 add/sub/xor SHALL complete with done=1 in the cycle after acceptance (latency 1).
REQ-014 add/sub SHALL wrap modulo 2^32; no carry/overflow output.
REQ-015 srl SHALL zero-fill from MSB; sll SHALL zero-fill from LSB; shift amount SHALL be srcB[4:0] only.
REQ-016 Shift with amount 0 SHALL go directly to DONE (latency 1, result=srcA).
REQ-017 Shift with amount n>0 SHALL enter SHIFT, shift one bit per cycle, and pulse done n+1 cycles after acceptance.
REQ-018 done SHALL be high exactly one cycle per accepted op; DONE returns to IDLE unless start accepted in that cycle.
REQ-019 result and zero SHALL update only on the cycle done rises and hold until the next done.
REQ-020 Back-to-back: start in DONE cycle SHALL be accepted, giving done every cycle for consecutive 1-latency ops.
REQ-021 Unsupported aluCtrl SHALL complete with latency 1 and result=0 (zero=1).

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, result=0, zero=0, err=0, shift counter=0.
REQ-023 Reset during SHIFT SHALL abort the op with no done pulse; first start after release SHALL behave as fresh.

Configuration
REQ-024 Macro ALU_ERR_EN SHALL compile in the err port and logic.
REQ-025 With ALU_ERR_EN: err=1 with done for unsupported codes, else 0; err holds with result.
REQ-026 Without ALU_ERR_EN: no err port; unsupported codes behave per REQ-021 silently.

Structure
REQ-027 Shared package alu_pkg SHALL hold the 4-bit op code constants (shared with the ALU control decoder) and the state enum.
REQ-028 One sub-module alu_shifter SHALL hold the shift register, down-counter and direction; top holds FSM, add/sub/xor and output registers.

Verification
REQ-029 add 5+7: start, aluCtrl=0010 -> next cycle done=1, result=12, zero=0.
REQ-030 sub 0x10-0x10, aluCtrl=0110 -> done after 1 cycle, result=0, zero=1; sub 0-1 -> 0xFFFFFFFF.
REQ-031 sll srcA=1, srcB=0x23 (amount 3) -> busy 3 cycles, done at cycle 4, result=8; start during busy ignored.
REQ-032 srl srcA=0x80000000, amount 31 -> done at cycle 32, result=1; amount 0 -> done cycle 1, result=srcA.
REQ-033 rst_n low at SHIFT cycle 2 -> outputs zero immediately, no done; then xor 0xF0^0xFF -> result 0x0F.
REQ-034 aluCtrl=0111 -> done cycle 1, result=0, zero=1, err=1 with ALU_ERR_EN; back-to-back adds give done on consecutive cycles.
